// File: rtl/alog_frame_src.sv
// ---------------------------------------------------------------------------
// alog_frame_src
//
// Transmit-side framer for the adaptive-filter top. Sample tuples
// (channel-2, channel-3, reference) arrive on a valid/ready interface and
// are queued in a small FIFO. Each frame takes one tuple off the FIFO,
// holds it on buffer_2/buffer_3/reff and raises head_flag for HEAD_LEN
// cycles, then drops head_flag for GAP_LEN cycles. The filter runs its
// adapt / weight-update / shift sequence while head_flag is high.
//
// Every output is registered or decoded from registered state, so outputs
// only change on posedge clk and stay stable when the consumer samples on
// negedge.
//
// Parameters:
//   DW        sample width of each channel
//   DEPTH     FIFO depth in tuples (power of 2, >= 2)
//   HEAD_LEN  cycles head_flag is high per frame (>= 19)
//   GAP_LEN   cycles head_flag is low between frames (>= 1)
//
// Ports:
//   clk         clock
//   rstn        asynchronous active-low reset
//   en          allow new frames to start
//   clr_stat    synchronous clear of underrun and frame_cnt
//   s_valid     upstream tuple valid
//   s_ready     upstream ready (FIFO not full)
//   s_buf2      upstream channel-2 sample
//   s_buf3      upstream channel-3 sample
//   s_reff      upstream reference sample
//   buffer_2    channel-2 sample to filter
//   buffer_3    channel-3 sample to filter
//   reff        reference sample to filter
//   head_flag   frame-active flag to filter
//   busy        high while a frame (HEAD or GAP) is in progress
//   underrun    sticky: a frame slot found the FIFO empty while enabled
//   frame_cnt   frames emitted, wraps at 16 bits
//   fifo_level  tuples currently stored
//
// Optional build macro:
//   ALOG_SRC_ZERO_FILL_EN  when defined, a GAP exit with en=1 and an empty
//                          FIFO still starts a frame, with zero samples, so
//                          the frame cadence never breaks while en=1.
//                          Underrun is still flagged and nothing is popped.
// ---------------------------------------------------------------------------
module alog_frame_src #(
    parameter int DW       = 14,
    parameter int DEPTH    = 8,
    parameter int HEAD_LEN = 24,
    parameter int GAP_LEN  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     clr_stat,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DW-1:0]            s_buf2,
    input  logic [DW-1:0]            s_buf3,
    input  logic [DW-1:0]            s_reff,
    output logic [DW-1:0]            buffer_2,
    output logic [DW-1:0]            buffer_3,
    output logic [DW-1:0]            reff,
    output logic                     head_flag,
    output logic                     busy,
    output logic                     underrun,
    output logic [15:0]              frame_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int PMAX = (HEAD_LEN > GAP_LEN) ? HEAD_LEN : GAP_LEN;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = 3 * DW;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [PW-1:0] HEAD_LAST  = PW'(HEAD_LEN);
    localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   phase;
    logic [PW-1:0]   phase_nxt;

    logic [TW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [TW-1:0]   rd_tuple;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            start_frame;
    logic            zero_frame;
    logic            set_underrun;

    // -----------------------------------------------------------------------
    // FIFO flags and handshake
    // -----------------------------------------------------------------------
    assign fifo_empty = (level == '0);
    assign s_ready    = (level != FULL_LEVEL);
    assign fifo_level = level;
    assign push       = s_valid && s_ready;
    assign pop        = start_frame;
    assign rd_tuple   = mem[rd_ptr];

    // Storage has no reset: an empty FIFO is defined by the pointers and
    // level alone, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_buf2, s_buf3, s_reff};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop in the same cycle leave the level unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM: state and phase counter register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM: next state and frame-start decisions
    // The phase counter restarts at 1 on entry to HEAD or GAP, so the state
    // is left at the edge where phase reaches the window length; this gives
    // exactly HEAD_LEN / GAP_LEN cycles per window. Frame-start checks use
    // the registered level, so a tuple pushed on this edge is visible on
    // the next one.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        start_frame  = 1'b0;
        zero_frame   = 1'b0;
        set_underrun = 1'b0;

        case (state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    start_frame = 1'b1;
                    state_nxt   = HEAD;
                    phase_nxt   = PHASE_ONE;
                end
            end

            HEAD: begin
                if (phase == HEAD_LAST) begin
                    state_nxt = GAP;
                    phase_nxt = PHASE_ONE;
                end else begin
                    phase_nxt = phase + PHASE_ONE;
                end
            end

            GAP: begin
                if (phase == GAP_LAST) begin
                    if (en && !fifo_empty) begin
                        start_frame = 1'b1;
                        state_nxt   = HEAD;
                        phase_nxt   = PHASE_ONE;
                    end else if (en) begin
                        set_underrun = 1'b1;
`ifdef ALOG_SRC_ZERO_FILL_EN
                        zero_frame   = 1'b1;
                        state_nxt    = HEAD;
                        phase_nxt    = PHASE_ONE;
`else
                        state_nxt    = IDLE;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    phase_nxt = phase + PHASE_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    assign head_flag = (state == HEAD);
    assign busy      = (state != IDLE);

    // -----------------------------------------------------------------------
    // Sample outputs: loaded only at frame start, so they never move while
    // head_flag is high. A zero-fill frame loads zeros instead of a tuple.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buffer_2 <= '0;
            buffer_3 <= '0;
            reff     <= '0;
        end else if (start_frame) begin
            buffer_2 <= rd_tuple[TW-1:2*DW];
            buffer_3 <= rd_tuple[2*DW-1:DW];
            reff     <= rd_tuple[DW-1:0];
        end else if (zero_frame) begin
            buffer_2 <= '0;
            buffer_3 <= '0;
            reff     <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics. A frame start or underrun event in the same cycle as
    // clr_stat wins, so nothing that happens on that edge is lost.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
            underrun  <= 1'b0;
        end else begin
            if (clr_stat) begin
                frame_cnt <= (start_frame || zero_frame) ? 16'd1 : 16'd0;
            end else if (start_frame || zero_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (set_underrun) begin
                underrun <= 1'b1;
            end else if (clr_stat) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alog_frame_src.sv
// ---------------------------------------------------------------------------
// tb_alog_frame_src
//
// Self-checking bench for alog_frame_src. A frame-level reference model
// tracks the FIFO contents as a queue, frame start times as cycle numbers
// and the statistics counters. Each predicted frame start pushes the
// expected tuple and frame count onto a scoreboard queue; a monitor pops
// and compares whenever the DUT raises head_flag. The monitor also checks
// the per-cycle status outputs against the model on every negedge.
// ---------------------------------------------------------------------------
module tb_alog_frame_src;

    localparam int DW       = 14;
    localparam int DEPTH    = 8;
    localparam int HEAD_LEN = 24;
    localparam int GAP_LEN  = 4;
    localparam int PERIOD   = HEAD_LEN + GAP_LEN;

    logic            clk;
    logic            rstn;
    logic            en;
    logic            clr_stat;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_buf2;
    logic [DW-1:0]   s_buf3;
    logic [DW-1:0]   s_reff;
    logic [DW-1:0]   buffer_2;
    logic [DW-1:0]   buffer_3;
    logic [DW-1:0]   reff;
    logic            head_flag;
    logic            busy;
    logic            underrun;
    logic [15:0]     frame_cnt;
    logic [3:0]      fifo_level;

    alog_frame_src #(
        .DW(DW), .DEPTH(DEPTH), .HEAD_LEN(HEAD_LEN), .GAP_LEN(GAP_LEN)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr_stat(clr_stat),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_buf2(s_buf2), .s_buf3(s_buf3), .s_reff(s_reff),
        .buffer_2(buffer_2), .buffer_3(buffer_3), .reff(reff),
        .head_flag(head_flag), .busy(busy), .underrun(underrun),
        .frame_cnt(frame_cnt), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] b2;
        logic [DW-1:0] b3;
        logic [DW-1:0] rf;
    } tuple_t;

    typedef struct {
        tuple_t      t;
        logic [15:0] cnt;
    } frame_t;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state
    tuple_t      modelQ[$];
    frame_t      sbQ[$];
    int          mCyc;
    int          mStart;
    bit          mActive;
    bit          mUnder;
    logic [15:0] mCnt;
    tuple_t      mCur;
    tuple_t      tmpT;
    frame_t      tmpF;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the active edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] b2,
                                 input logic [DW-1:0] b3,
                                 input logic [DW-1:0] rf,
                                 input logic e, input logic c);
        @(posedge clk);
        #1;
        s_valid  = v;
        s_buf2   = b2;
        s_buf3   = b3;
        s_reff   = rf;
        en       = e;
        clr_stat = c;
    endtask

    task automatic idleCycles(input int n, input logic e);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, '0, e, 1'b0);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: frames are described by their start cycle; a new
    // frame may begin when none is running or exactly PERIOD cycles after
    // the previous start.
    // -----------------------------------------------------------------------
    initial begin
        mCyc = 0; mStart = 0; mActive = 0; mUnder = 0; mCnt = '0;
        mCur = '{b2: '0, b3: '0, rf: '0};
        forever begin
            bit gapExit;
            bit slot;
            bit startF;
            bit zeroF;
            bit setU;
            bit pushOk;
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                modelQ.delete();
                sbQ.delete();
                mCyc = 0; mStart = 0; mActive = 0; mUnder = 0; mCnt = '0;
                mCur = '{b2: '0, b3: '0, rf: '0};
            end else begin
                pushOk  = s_valid && (modelQ.size() != DEPTH);
                gapExit = mActive && (mCyc - mStart == PERIOD);
                slot    = !mActive || gapExit;
                startF  = 0;
                zeroF   = 0;
                setU    = 0;
                if (slot) begin
                    if (en && modelQ.size() > 0) begin
                        startF = 1;
                    end else if (gapExit && en) begin
                        setU = 1;
`ifdef ALOG_SRC_ZERO_FILL_EN
                        zeroF = 1;
`endif
                    end
                end
                if (startF) begin
                    mCur = modelQ.pop_front();
                end else if (zeroF) begin
                    mCur = '{b2: '0, b3: '0, rf: '0};
                end
                if (clr_stat) begin
                    mCnt = (startF || zeroF) ? 16'd1 : 16'd0;
                end else if (startF || zeroF) begin
                    mCnt = mCnt + 16'd1;
                end
                if (startF || zeroF) begin
                    mStart  = mCyc;
                    mActive = 1;
                    tmpF.t   = mCur;
                    tmpF.cnt = mCnt;
                    sbQ.push_back(tmpF);
                end else if (gapExit) begin
                    mActive = 0;
                end
                if (setU) begin
                    mUnder = 1;
                end else if (clr_stat) begin
                    mUnder = 0;
                end
                if (pushOk) begin
                    tmpT.b2 = s_buf2;
                    tmpT.b3 = s_buf3;
                    tmpT.rf = s_reff;
                    modelQ.push_back(tmpT);
                end
                mCyc++;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monitor: per-cycle status checks and scoreboard pops on head_flag rise.
    // -----------------------------------------------------------------------
    initial begin
        logic prevHead;
        logic expHead;
        prevHead = 1'b0;
        forever begin
            @(negedge clk);
            expHead = mActive && ((mCyc - 1 - mStart) < HEAD_LEN);
            checkOutput("head_flag", 32'(head_flag), 32'(expHead));
            checkOutput("busy", 32'(busy), 32'(mActive));
            checkOutput("underrun", 32'(underrun), 32'(mUnder));
            checkOutput("fifo_level", 32'(fifo_level), 32'(modelQ.size()));
            checkOutput("s_ready", 32'(s_ready),
                        32'(modelQ.size() != DEPTH));
            checkOutput("frame_cnt", 32'(frame_cnt), 32'(mCnt));
            checkOutput("samples", {4'h0, buffer_2, buffer_3[13:0]} ^ 32'(reff),
                        {4'h0, mCur.b2, mCur.b3} ^ 32'(mCur.rf));
            if (rstn && head_flag && !prevHead) begin
                if (sbQ.size() == 0) begin
                    checkOutput("frame_expected", 32'd1, 32'd0);
                end else begin
                    tmpF = sbQ.pop_front();
                    checkOutput("frame_b2", 32'(buffer_2), 32'(tmpF.t.b2));
                    checkOutput("frame_b3", 32'(buffer_3), 32'(tmpF.t.b3));
                    checkOutput("frame_reff", 32'(reff), 32'(tmpF.t.rf));
                    checkOutput("frame_cnt_at_start", 32'(frame_cnt),
                                32'(tmpF.cnt));
                end
            end
            prevHead = head_flag;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int pv;
        logic e;
        rstn = 1'b0; en = 1'b0; clr_stat = 1'b0; s_valid = 1'b0;
        s_buf2 = '0; s_buf3 = '0; s_reff = '0;
        idleCycles(3, 1'b0);
        @(posedge clk); #1; rstn = 1'b1;

        // Single tuple, full frame then back to idle.
        applyStimulus(1'b1, 14'h0123, 14'h0456, 14'h0789, 1'b1, 1'b0);
        idleCycles(PERIOD + 8, 1'b1);

        // Fill with en low, offer a ninth tuple, then drain back-to-back.
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b1, 14'(i * 3 + 1), 14'(i * 5 + 2),
                          14'(i * 7 + 3), 1'b0, 1'b0);
        end
        idleCycles(4, 1'b0);
        idleCycles(DEPTH * PERIOD + 10, 1'b1);

        // Three frames of feed then starve: underrun, then clear.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 14'($urandom), 14'($urandom), 14'($urandom),
                          1'b1, 1'b0);
        end
        idleCycles(3 * PERIOD + 10, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1);
        idleCycles(4, 1'b1);

        // en dropped mid-HEAD with tuples still queued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 14'($urandom), 14'($urandom), 14'($urandom),
                          1'b1, 1'b0);
        end
        idleCycles(8, 1'b1);
        idleCycles(PERIOD + 10, 1'b0);

        // Reset in the middle of HEAD, then a fresh frame.
        idleCycles(PERIOD * 3, 1'b1);
        applyStimulus(1'b1, 14'h1abc, 14'h0def, 14'h2345, 1'b1, 1'b0);
        idleCycles(12, 1'b1);
        rstn = 1'b0;
        idleCycles(3, 1'b1);
        @(posedge clk); #1; rstn = 1'b1;
        applyStimulus(1'b1, 14'h0a5a, 14'h15a5, 14'h3fff, 1'b1, 1'b0);
        idleCycles(PERIOD + 6, 1'b1);

        // Randomized traffic with varying source rate, en and clr_stat.
        e = 1'b1;
        for (int seg = 0; seg < 6; seg++) begin
            pv = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 5 : 40);
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 199) == 0) e = ~e;
                applyStimulus($urandom_range(0, 99) < pv, 14'($urandom),
                              14'($urandom), 14'($urandom), e,
                              $urandom_range(0, 99) == 0);
            end
        end
        idleCycles((DEPTH + 2) * PERIOD, 1'b1);
        idleCycles(PERIOD + 4, 1'b0);

        checkOutput("pending_frames", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
